alu_seq: RTL and testbench

- Parametrised, clocked successor to the team's 8-bit combinational ALU.
- Accepts one operation at a time through a valid/ready input handshake and returns a registered result with status flags through a valid/ready output handshake.
- Adds XOR, shifts and a multi-cycle shift-add multiplier.
- Sits between the operand/control front end and the register-writeback stage of the datapath.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/op input handshake and result/flag output handshake
// for alu_seq. The master drives operations and accepts results; the slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_neg;
  logic             out_err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_carry, flag_neg, out_err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_carry, flag_neg, out_err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready handshakes on both sides.
// Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
// Optional macro ALU_MUL_EN: when defined, op 7 is a WIDTH-cycle shift-add
// multiplier (EXEC state). When undefined, op 7 completes in one cycle with
// result 0 and out_err set.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             neg_q;
  logic             err_q;

  // Single-cycle datapath: the extra top bit of each extended result
  // is the carry, borrow or shift-out bit.
  logic [SHW-1:0]   amt_d;
  logic [WIDTH:0]   add_d;
  logic [WIDTH:0]   sub_d;
  logic [WIDTH:0]   shl_d;
  logic [WIDTH:0]   shr_d;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             err_d;

  // Combinational result and carry for the one-cycle ops.
  always_comb begin
    amt_d   = bus.b[SHW-1:0];
    add_d   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_d   = {1'b0, bus.a} - {1'b0, bus.b};
    shl_d   = {1'b0, bus.a} << amt_d;
    shr_d   = {bus.a, 1'b0} >> amt_d;
    res_d   = '0;
    carry_d = 1'b0;
    err_d   = 1'b0;
    case (bus.op)
      3'd0: {carry_d, res_d} = add_d;
      3'd1: {carry_d, res_d} = sub_d;
      3'd2: res_d = bus.a & bus.b;
      3'd3: res_d = bus.a | bus.b;
      3'd4: res_d = bus.a ^ bus.b;
      3'd5: {carry_d, res_d} = shl_d;
      3'd6: begin
        res_d   = shr_d[WIDTH:1];
        carry_d = shr_d[0];
      end
      // Op 7 only reaches this path when the multiplier is absent.
      default: err_d = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // Multiplier state: prod_q holds {partial high half, remaining multiplier bits}.
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH:0]     hi_sum_d;
  logic [2*WIDTH-1:0] prod_d;

  // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
  always_comb begin
    hi_sum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      hi_sum_d = hi_sum_d + {1'b0, mcand_q};
    end
    prod_d = {hi_sum_d, prod_q[WIDTH-1:1]};
  end
`endif

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
`ifdef ALU_MUL_EN
            if (bus.op == 3'd7) begin
              state_q <= EXEC;
              prod_q  <= {{WIDTH{1'b0}}, bus.b};
              mcand_q <= bus.a;
              cnt_q   <= '0;
            end else
`endif
            begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              zero_q      <= (res_d == '0);
              carry_q     <= carry_d;
              neg_q       <= res_d[WIDTH-1];
              err_q       <= err_d;
            end
          end
        end
`ifdef ALU_MUL_EN
        EXEC: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= prod_d[WIDTH-1:0];
            zero_q      <= (prod_d[WIDTH-1:0] == '0);
            carry_q     <= |prod_d[2*WIDTH-1:WIDTH];
            neg_q       <= prod_d[WIDTH-1];
            err_q       <= 1'b0;
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_neg   = neg_q;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8). Expected responses are
// computed with plain integer arithmetic and queued at issue; a negedge
// monitor checks latency, hold stability, handshake and response contents.
module tb_alu_seq;
  localparam int     W = 8;
  localparam longint M = longint'(1) << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    longint res;
    bit     z, c, n, e;
    int     lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;

  // Monitor state
  bit         prev_valid = 0, hs_prev = 0, busy = 0;
  logic [W-1:0] held_res;
  logic         held_z, held_c, held_n, held_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference behaviour from the arithmetic rules.
  function automatic exp_t model(input longint a, input longint b, input int op);
    exp_t   e;
    longint amt, p;
    amt = b % W;
    e.res = 0; e.c = 0; e.e = 0; e.lat = 1;
    case (op)
      0: begin p = a + b; e.res = p % M; e.c = (p >= M); end
      1: begin e.res = (a - b + M) % M; e.c = (a < b); end
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: begin e.res = (a << amt) % M; e.c = (amt != 0) && (((a >> (W - amt)) & 1) != 0); end
      6: begin e.res = a >> amt; e.c = (amt != 0) && (((a >> (amt - 1)) & 1) != 0); end
      default: begin
`ifdef ALU_MUL_EN
        p = a * b; e.res = p % M; e.c = (p >= M); e.lat = W + 1;
`else
        e.res = 0; e.e = 1;
`endif
      end
    endcase
    e.z = (e.res == 0);
    e.n = (e.res >= M / 2);
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_valid = 0; hs_prev = 0; busy = 0;
    end else begin
      if (hs_prev) begin
        check("post_hs_out_valid", bus.out_valid, 0);
        check("post_hs_in_ready", bus.in_ready, 1);
      end
      hs_prev = 0;
      if (busy) check("busy_in_ready", bus.in_ready, 0);
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cyc);
        busy = 1;
      end
      if (bus.out_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL stale_output: got out_valid=1 result=%0d required no pending output", bus.result);
          end else begin
            check("latency", cyc - acc_q.pop_front(), exp_q[0].lat);
          end
          held_res = bus.result; held_z = bus.flag_zero; held_c = bus.flag_carry;
          held_n = bus.flag_neg; held_e = bus.out_err;
        end else begin
          check("hold_result", bus.result, held_res);
          check("hold_flags", {bus.flag_zero, bus.flag_carry, bus.flag_neg, bus.out_err},
                {held_z, held_c, held_n, held_e});
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", bus.result, e.res);
            check("flag_zero", bus.flag_zero, e.z);
            check("flag_carry", bus.flag_carry, e.c);
            check("flag_neg", bus.flag_neg, e.n);
            check("out_err", bus.out_err, e.e);
            $display("txn: result=%0d z=%0d c=%0d n=%0d err=%0d", bus.result, bus.flag_zero,
                     bus.flag_carry, bus.flag_neg, bus.out_err);
          end
          hs_prev = 1;
          busy = 0;
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic issue(input longint a, input longint b, input int op);
    bit ok;
    exp_q.push_back(model(a, b, op));
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a = W'(a); bus.b = W'(b); bus.op = 3'(op);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 3'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_flags"}, {bus.flag_zero, bus.flag_carry, bus.flag_neg, bus.out_err}, 0);
  endtask

  // Random out_ready generator, active only during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed vectors: {a, b, op}
  longint dir_a[10]  = '{7, 3, 200, 'h81, 'h81, 'h0F, 'hA5, 'h50, 15, 16};
  longint dir_b[10]  = '{3, 7, 100, 1,    9,    'hF0, 'h3C, 'h0A, 17, 16};
  int     dir_op[10] = '{0, 1, 0,   5,    6,    2,    4,    3,    7,  7};

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    for (int i = 0; i < 10; i++) begin
      issue(dir_a[i], dir_b[i], dir_op[i]);
      drain();
    end

    // Backpressure: result pending with out_ready low, new in_valid must be ignored.
    bus.out_ready = 1'b0;
    issue('h5A, 'h33, 4);
    bus.in_valid = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.op = 3'd0;
    repeat (6) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of an operation.
`ifdef ALU_MUL_EN
    issue(200, 77, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
`else
    bus.out_ready = 1'b0;
    issue(200, 77, 0);
    @(posedge clk); #1;
    rst = 1'b1;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_state("midop_reset");
    repeat (12) @(negedge clk);

    // Random phase with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      issue($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
    end
    drain();
    rand_rdy = 0;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
